// File: rtl/aes_block_serializer_pkg.sv
// rtl/aes_block_serializer_pkg.sv - shared state encoding and block constants
// Purpose: state enum for the serializer FSM, block byte count and the
//          largest legal PKCS#7 pad value.
// Ports:   none (package).
package aes_block_serializer_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int PAD_MAX     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/aes_block_serializer_pkcs7_check.sv
// rtl/aes_block_serializer_pkcs7_check.sv - combinational PKCS#7 padding checker
// Purpose: inspects a 128-bit block whose byte 0 (MSB) is sent first and
//          decides whether its trailing bytes form legal PKCS#7 padding.
// Ports:   block_i   - 128-bit plaintext block
//          valid_o   - 1 when pad value P is 1..16 and the last P bytes equal P
//          pad_len_o - P when valid_o, else 0
module aes_block_serializer_pkcs7_check
  import aes_block_serializer_pkg::*;
(
  input  logic [127:0] block_i,
  output logic         valid_o,
  output logic [4:0]   pad_len_o
);

  logic [7:0] pad;

  // The pad value sits in the byte sent last, which is the LSB byte.
  assign pad = block_i[7:0];

  always_comb begin
    valid_o = (pad >= 8'd1) && (pad <= 8'(PAD_MAX));
    // Byte i here counts from the LSB end, so bytes 0..P-1 are the pad bytes.
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if ((i < int'(pad)) && (block_i[8*i +: 8] != pad)) begin
        valid_o = 1'b0;
      end
    end
    pad_len_o = valid_o ? pad[4:0] : 5'd0;
  end

endmodule

// File: rtl/aes_block_serializer.sv
// rtl/aes_block_serializer.sv - 128-bit block to byte stream serializer with PKCS#7 strip
// Purpose: accepts decrypted 128-bit blocks, optionally strips PKCS#7 padding
//          from the final block of a frame and emits the bytes MSB first.
// Ports:   clk_i, rst_ni (sync active-low), en_i (0 acts as reset)
//          pad_strip_i            - strip request, sampled with the block
//          s_axis_t*              - 128-bit block input, tlast = final block
//          m_axis_t*              - 8-bit byte output, tkeep constant 1
//          pad_error_o            - pulse when a strip attempt finds bad padding
//          frame_done_o           - pulse after the last byte of a frame
module aes_block_serializer
  import aes_block_serializer_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         pad_strip_i,
  input  logic [127:0] s_axis_tdata_i,
  input  logic         s_axis_tvalid_i,
  input  logic         s_axis_tlast_i,
  output logic         s_axis_tready_o,
  output logic [7:0]   m_axis_tdata_o,
  output logic         m_axis_tvalid_o,
  output logic         m_axis_tlast_o,
  output logic         m_axis_tkeep_o,
  input  logic         m_axis_tready_i,
  output logic         pad_error_o,
  output logic         frame_done_o
);

  state_e       state_q, state_d;
  logic [127:0] buf_q, buf_d;
  logic         last_q, last_d;
  logic         strip_q, strip_d;
  logic [4:0]   num_bytes_q, num_bytes_d;
  logic [3:0]   byte_cnt_q, byte_cnt_d;

  logic         active;
  logic         pad_valid;
  logic [4:0]   pad_len;
  logic [7:0]   cur_byte;
  logic         last_byte;

  // En low is treated exactly like reset.
  assign active         = rst_ni & en_i;
  assign m_axis_tkeep_o = 1'b1;

  aes_block_serializer_pkcs7_check u_pkcs7_check (
    .block_i   (buf_q),
    .valid_o   (pad_valid),
    .pad_len_o (pad_len)
  );

  // Byte 0 of the stream is the MSB byte of the block.
  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (byte_cnt_q == 4'(i)) begin
        cur_byte = buf_q[127 - 8*i -: 8];
      end
    end
  end

  assign last_byte = ({1'b0, byte_cnt_q} == (num_bytes_q - 5'd1));

  always_comb begin
    state_d         = state_q;
    buf_d           = buf_q;
    last_d          = last_q;
    strip_d         = strip_q;
    num_bytes_d     = num_bytes_q;
    byte_cnt_d      = byte_cnt_q;
    s_axis_tready_o = 1'b0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = 8'h00;
    m_axis_tlast_o  = 1'b0;
    pad_error_o     = 1'b0;
    frame_done_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s_axis_tready_o = 1'b1;
        if (s_axis_tvalid_i) begin
          buf_d   = s_axis_tdata_i;
          last_d  = s_axis_tlast_i;
          strip_d = pad_strip_i;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        num_bytes_d = 5'(BLOCK_BYTES);
        // Only a final block with a strip request is ever inspected.
        if (strip_q && last_q) begin
          if (pad_valid) begin
            num_bytes_d = 5'(BLOCK_BYTES) - pad_len;
          end else begin
            pad_error_o = 1'b1;
          end
        end
        byte_cnt_d = 4'd0;
        state_d    = (num_bytes_d != 5'd0) ? ST_SHIFT : ST_DONE;
      end

      ST_SHIFT: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = cur_byte;
        m_axis_tlast_o  = last_q && last_byte;
        if (m_axis_tready_i) begin
          if (last_byte) begin
            state_d = last_q ? ST_DONE : ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end

      ST_DONE: begin
        frame_done_o = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs read as reset values in the same cycle reset or En drops.
    if (!active) begin
      s_axis_tready_o = 1'b0;
      m_axis_tvalid_o = 1'b0;
      m_axis_tdata_o  = 8'h00;
      m_axis_tlast_o  = 1'b0;
      pad_error_o     = 1'b0;
      frame_done_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!active) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      last_q      <= 1'b0;
      strip_q     <= 1'b0;
      num_bytes_q <= '0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      last_q      <= last_d;
      strip_q     <= strip_d;
      num_bytes_q <= num_bytes_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

endmodule

// File: doc/aes_block_serializer.md
AES_BLOCK_SERIALIZER -- requirements
Module: aes_block_serializer

Interface
REQ-001 Clk  input  1  single clock; all logic on rising edge.
REQ-002 Rst  input  1  synchronous reset, active-low (Rst=0 resets on next rising Clk edge).
REQ-003 En  input  1  block enable; En=0 behaves exactly as reset.
REQ-004 PadStrip  input  1  1 = remove PKCS#7 padding from the final block of a frame; sampled when a block is accepted.
REQ-005 s_axis  my_axis_if.slave  128-bit tdata  plaintext blocks from the inverse cipher; tlast marks the final block of a frame.
REQ-006 m_axis  my_axis_if.master  8-bit tdata  plaintext byte stream toward UART TX; tkeep is constant all-ones.
REQ-007 PadError  output  1  one-cycle pulse when padding checked on a final block is invalid.
REQ-008 FrameDone  output  1  one-cycle pulse when the last byte of a frame has been handed off, or would have been.

Function
REQ-009 States: IDLE, CHECK, SHIFT, DONE; encoding lives in the shared package.
REQ-010 IDLE: s_axis.tready=1, m_axis.tvalid=0.
  - On s_axis.tvalid: latch tdata to BufReg, tlast to LastReg, PadStrip to StripReg.
  - Then go to CHECK.
REQ-011 CHECK (exactly one cycle, tready=0): compute NumBytes (5-bit, 0..16).
  - Rule: P = BufReg[7:0].
  - If StripReg=1 and LastReg=1 and P is in 1..16 and the last P bytes all equal P: NumBytes = 16-P.
  - Otherwise: NumBytes = 16.
  - If stripping was attempted and failed, pulse PadError in this cycle and keep NumBytes = 16.
REQ-012 CHECK exit: ByteCnt = 0; go to SHIFT if NumBytes > 0, else go to DONE.
REQ-013 SHIFT: m_axis.tvalid=1 and m_axis.tdata = BufReg[127-8*ByteCnt -: 8], sent MSB byte first.
  - ByteCnt advances only on the cycle where tvalid and tready are both 1.
  - tdata holds stable while tready=0.
REQ-014 m_axis.tlast=1 only on byte ByteCnt = NumBytes-1 when LastReg=1; otherwise 0.
REQ-015 On the handshake of byte NumBytes-1: go to DONE if LastReg=1, else go to IDLE.
REQ-016 DONE (one cycle): pulse FrameDone, then go to IDLE.
REQ-017 Latency: block accepted at cycle T; first byte valid at T+2; with tready held 1, a 16-byte block occupies T+2..T+17; next block accepted no earlier than T+18 (T+19 after DONE).
REQ-018 Padding 0x10 (P=16) strips the whole block: no bytes, no tlast, FrameDone still pulses.
REQ-019 P=0 or P>16 is invalid padding; the block is emitted in full with tlast on byte 15.
REQ-020 A non-final block (tlast=0) is never stripped, regardless of PadStrip.
REQ-021 Unused states return to IDLE.

Reset
REQ-022 While Rst=0 or En=0:
  - State=IDLE; BufReg, ByteCnt, LastReg, StripReg, NumBytes = 0.
  - m_axis.tvalid=0, tdata=0, tlast=0; PadError=0; FrameDone=0.
  - s_axis.tready=0.
REQ-023 Reset or En deassertion mid-block discards the partially sent block; nothing resumes afterwards.

Structure
REQ-024 Shared package holds the state enum, the block byte count (16) and the PKCS#7 maximum pad value (16).
REQ-025 One sub-module, pkcs7_check: combinational; inputs are the 128-bit block; outputs are valid and pad length.

Verification
REQ-026 Block 0x00112233445566778899AABBCCDDEEFF, tlast=0, tready=1 -> bytes 0x00..0xFF in order, at cycles T+2..T+17; no tlast, no FrameDone.
REQ-027 Final block ending in 03 03 03, PadStrip=1 -> 13 bytes; tlast on 13th byte; FrameDone one cycle later; PadError=0.
REQ-028 Final block of sixteen 0x10 bytes, PadStrip=1 -> no m_axis.tvalid; FrameDone pulses at T+2.
REQ-029 Final block ending 02 05, PadStrip=1 -> PadError at T+1; all 16 bytes; tlast on byte 16.
REQ-030 tready toggled 1,0,0,1 during SHIFT -> tdata stable while tready=0; no byte lost or duplicated.
REQ-031 Rst=0 asserted after 5 bytes of a block -> outputs at reset values next cycle; a new block afterwards starts at byte 0.
